dmem_requester: RTL and testbench
=================================

DMEM_REQUESTER -- requirements
Module: dmem_requester

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 6, SHALL set the byte-address width of the attached data memory; addresses at or above 2**MEM_ADDR_BITS are out of range.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL set the cycle budget from bus issue to response before a timeout error.
REQ-003 Ports SHALL be as follows. The block has one clock; reset is synchronous and active-high.
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  core command present
- cmd_ready  output  1  block accepts a command
- cmd_addr  input  32  byte address
- cmd_wdata  input  32  store data, right-aligned
- cmd_fcn  input  1  1 = store, 0 = load
- cmd_typ  input  3  1 = byte, 2 = half, 3 = word
- cmd_signed  input  1  sign-extend load result
- rsp_valid  output  1  one-cycle result strobe
- rsp_data  output  32  load result (0 for stores and errors)
- rsp_err  output  2  0 ok, 1 misaligned/illegal typ, 2 out of range, 3 timeout
- dmem_in_io_dmem_req_bits_addr  output  32  bus address
- dmem_in_io_dmem_req_bits_data  output  32  bus store data
- dmem_in_io_dmem_req_bits_fcn  output  1  bus function
- dmem_in_io_dmem_req_bits_typ  output  3  bus size
- dmem_in_io_dmem_req_valid  output  1  bus request valid
- dmem_ou_io_dmem_req_ready  input  1  memory accepts request
- dmem_ou_io_dmem_resp_valid  input  1  memory response strobe
- dmem_ou_io_dmem_resp_bits_data  input  32  zero-extended read data

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and RESP; cmd_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-005 In IDLE, a cmd_valid&&cmd_ready edge SHALL register addr, wdata, fcn, typ and signed.
REQ-006 On acceptance, the command SHALL be checked:
- typ 0 or typ>3 -> err 1
- half with addr[0]=1 -> err 1
- word with addr[1:0]!=0 -> err 1
- addr >= 2**MEM_ADDR_BITS -> err 2
- Err 1 takes priority over err 2.
REQ-007 An erroring command SHALL go directly to RESP and SHALL NOT issue on the bus.
REQ-008 A legal command SHALL go to REQ.
REQ-009 In REQ, dmem_in_io_dmem_req_valid SHALL be 1 and the bus fields SHALL equal the registered command, held stable until accepted.
REQ-010 A request SHALL be accepted at a clock edge where req_valid and dmem_ou_io_dmem_req_ready are both 1; the FSM then moves to WAIT.
REQ-011 req_valid SHALL be 0 in every state other than REQ, including the cycle after acceptance.
REQ-012 dmem_ou_io_dmem_resp_valid seen in REQ or IDLE SHALL be ignored.
REQ-013 In WAIT, resp_valid=1 SHALL capture the response and move the FSM to RESP with err 0.
REQ-014 Load result formatting:
- byte: data[7:0], bits 31:8 = signed ? data[7] : 0
- half: data[15:0], bits 31:16 = signed ? data[15] : 0
- word: data unchanged
- stores return rsp_data 0
REQ-015 A timeout counter SHALL clear on command acceptance and increment on each cycle spent in REQ or WAIT.
REQ-016 When the counter reaches TIMEOUT_CYCLES without a captured response, the FSM SHALL go to RESP with err 3 and rsp_data 0.
REQ-017 If a response arrives on the same edge the timeout fires, the response SHALL win.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 With a zero-delay memory, rsp_valid SHALL assert 3 cycles after the cmd handshake edge for a legal command, and 1 cycle after it for an error.
REQ-020 The maximum throughput SHALL be one command per 4 cycles.

Reset
REQ-021 reset=1 at a clock edge SHALL force IDLE and clear the timeout counter and all registered command fields.
REQ-022 Reset values SHALL be: cmd_ready=1 in the cycle after reset, rsp_valid=0, rsp_data=0, rsp_err=0, dmem_in_io_dmem_req_valid=0, and all bus fields 0.
REQ-023 Reset in REQ or WAIT SHALL abandon the transaction with no rsp_valid; a response arriving after reset SHALL be ignored.

Verification
REQ-024 Word store addr 0x8, data 0xDEADBEEF, then word load 0x8 -> load rsp_valid 3 cycles after the handshake, rsp_data 0xDEADBEEF, err 0.
REQ-025 Memory word 0x8 = 0x00F08000; byte load signed at 0xA -> 0xFFFFFFF0; half load signed at 0x8 -> 0xFFFF8000; byte load unsigned at 0xA -> 0x000000F0.
REQ-026 Word load at 0x6, and half load at 0x5 -> err 1 one cycle after the handshake, no req_valid pulse.
REQ-027 Word load at 0x40 with MEM_ADDR_BITS=6 -> err 2; typ=0 with addr 0x40 -> err 1.
REQ-028 Memory stub that never asserts resp_valid -> err 3, rsp_data 0, with rsp_valid at cycle TIMEOUT_CYCLES+1 after the handshake; a response landing on the timeout edge -> err 0.
REQ-029 Reset asserted while in WAIT, then a late resp_valid -> no rsp_valid, cmd_ready=1, req_valid=0.

Source files
------------

// File: rtl/dmem_requester.sv
// rtl/dmem_requester.sv - single-outstanding data-memory requester between a core and a simple bus
//
// Accepts one load/store command at a time, checks alignment, size and range,
// issues it on the memory bus, waits for the response (or a timeout), formats
// load data and returns a one-cycle result strobe.
//
// Ports:
//   clock, reset                      sole clock; synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (ready only when idle)
//   cmd_addr, cmd_wdata, cmd_fcn,
//   cmd_typ, cmd_signed               byte address, store data, 1=store,
//                                     1/2/3 = byte/half/word, sign-extend loads
//   rsp_valid, rsp_data, rsp_err      one-cycle result: data, 0 ok / 1 illegal /
//                                     2 out of range / 3 timeout
//   dmem_in_io_dmem_req_*             bus request (valid only while requesting)
//   dmem_ou_io_dmem_req_ready         bus accepts the request
//   dmem_ou_io_dmem_resp_valid/_data  bus response strobe and zero-extended data

module dmem_requester #(
  parameter int MEM_ADDR_BITS  = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_fcn,
  input  logic [2:0]  cmd_typ,
  input  logic        cmd_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic [31:0] dmem_in_io_dmem_req_bits_addr,
  output logic [31:0] dmem_in_io_dmem_req_bits_data,
  output logic        dmem_in_io_dmem_req_bits_fcn,
  output logic [2:0]  dmem_in_io_dmem_req_bits_typ,
  output logic        dmem_in_io_dmem_req_valid,
  input  logic        dmem_ou_io_dmem_req_ready,
  input  logic        dmem_ou_io_dmem_resp_valid,
  input  logic [31:0] dmem_ou_io_dmem_resp_bits_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter is sampled before its increment, so the edge on which it
  // would reach TIMEOUT_CYCLES is the one where it still reads one less.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             fcn_q;
  logic [2:0]       typ_q;
  logic             signed_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      rsp_data_q;
  logic [1:0]       rsp_err_q;

  logic             typ_bad;
  logic             range_bad;
  logic             tmo_hit;
  logic [31:0]      load_fmt;

  always_comb begin
    typ_bad = 1'b0;
    case (cmd_typ)
      3'd1:    typ_bad = 1'b0;
      3'd2:    typ_bad = cmd_addr[0];
      3'd3:    typ_bad = |cmd_addr[1:0];
      default: typ_bad = 1'b1;
    endcase
  end

  assign range_bad = (cmd_addr >> MEM_ADDR_BITS) != 32'd0;
  assign tmo_hit   = (tmo_cnt == CNT_LAST);

  always_comb begin
    load_fmt = 32'd0;
    if (!fcn_q) begin
      case (typ_q)
        3'd1:    load_fmt = {{24{signed_q & dmem_ou_io_dmem_resp_bits_data[7]}},
                             dmem_ou_io_dmem_resp_bits_data[7:0]};
        3'd2:    load_fmt = {{16{signed_q & dmem_ou_io_dmem_resp_bits_data[15]}},
                             dmem_ou_io_dmem_resp_bits_data[15:0]};
        default: load_fmt = dmem_ou_io_dmem_resp_bits_data;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      fcn_q      <= 1'b0;
      typ_q      <= 3'd0;
      signed_q   <= 1'b0;
      tmo_cnt    <= '0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            fcn_q    <= cmd_fcn;
            typ_q    <= cmd_typ;
            signed_q <= cmd_signed;
            tmo_cnt  <= '0;
            // Illegal size/alignment outranks out-of-range.
            if (typ_bad) begin
              rsp_err_q <= 2'd1;
              state     <= RESP;
            end else if (range_bad) begin
              rsp_err_q <= 2'd2;
              state     <= RESP;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            rsp_err_q <= 2'd3;
            state     <= RESP;
          end else if (dmem_ou_io_dmem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A response on the timeout edge still counts as a success.
          if (dmem_ou_io_dmem_resp_valid) begin
            rsp_data_q <= load_fmt;
            rsp_err_q  <= 2'd0;
            state      <= RESP;
          end else if (tmo_hit) begin
            rsp_err_q <= 2'd3;
            state     <= RESP;
          end
        end
        default: begin
          // Result fields read back as zero outside the strobe cycle.
          rsp_data_q <= 32'd0;
          rsp_err_q  <= 2'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  assign dmem_in_io_dmem_req_valid     = (state == REQ);
  assign dmem_in_io_dmem_req_bits_addr = addr_q;
  assign dmem_in_io_dmem_req_bits_data = wdata_q;
  assign dmem_in_io_dmem_req_bits_fcn  = fcn_q;
  assign dmem_in_io_dmem_req_bits_typ  = typ_q;

endmodule

// File: tb/tb_dmem_requester.sv
// tb/tb_dmem_requester.sv - randomized self-checking bench for dmem_requester
module tb_dmem_requester;

  localparam int MAB = 6;
  localparam int TMO = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        cmd_fcn = 1'b0;
  logic [2:0]  cmd_typ = 3'd0;
  logic        cmd_signed = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] bus_addr, bus_data;
  logic        bus_fcn, req_valid;
  logic [2:0]  bus_typ;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'd0;

  dmem_requester #(.MEM_ADDR_BITS(MAB), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_fcn(cmd_fcn), .cmd_typ(cmd_typ),
    .cmd_signed(cmd_signed),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dmem_in_io_dmem_req_bits_addr(bus_addr),
    .dmem_in_io_dmem_req_bits_data(bus_data),
    .dmem_in_io_dmem_req_bits_fcn(bus_fcn),
    .dmem_in_io_dmem_req_bits_typ(bus_typ),
    .dmem_in_io_dmem_req_valid(req_valid),
    .dmem_ou_io_dmem_req_ready(req_ready),
    .dmem_ou_io_dmem_resp_valid(resp_valid),
    .dmem_ou_io_dmem_resp_bits_data(resp_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;
  exp_t expq[$];

  // current command as the bus should present it
  bit          exp_bus = 1'b0;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_fcn;
  logic [2:0]  cur_typ;
  int          cur_h = 0;

  int          last_lat = 0;
  logic [31:0] last_data = 32'd0;
  logic [1:0]  last_err = 2'd0;

  logic [7:0]  ref_mem [64];
  logic [7:0]  smem [64];

  // memory stub: accepts after stub_dr REQ cycles, answers stub_dw cycles
  // after acceptance (0 = never answers)
  int          stub_dr = 0, stub_dw = 1, rwait = 0, rcnt = 0, snb = 0;
  bit          acc_pending = 1'b0, stub_busy = 1'b0;
  logic [31:0] lat_addr, lat_wdata, pend_rdata;
  logic        lat_fcn;
  logic [2:0]  lat_typ;

  always @(negedge clock) begin
    if (acc_pending) begin
      acc_pending = 1'b0;
      snb = (lat_typ == 3'd1) ? 1 : (lat_typ == 3'd2) ? 2 : 4;
      pend_rdata = 32'd0;
      for (int i = 0; i < snb; i++) begin
        if (lat_fcn) smem[(lat_addr + i) % 64] = lat_wdata[8*i +: 8];
        else pend_rdata[8*i +: 8] = smem[(lat_addr + i) % 64];
      end
      if (lat_fcn) pend_rdata = $urandom;
      rcnt = stub_dw;
    end
    resp_valid = 1'b0;
    resp_data = $urandom;
    if (rcnt > 0) begin
      if (rcnt == 1) begin
        resp_valid = 1'b1;
        resp_data = pend_rdata;
      end
      rcnt--;
    end
    if (req_valid === 1'b1) begin
      req_ready = (rwait >= stub_dr);
      if (req_ready) begin
        lat_addr = bus_addr; lat_wdata = bus_data;
        lat_fcn = bus_fcn; lat_typ = bus_typ;
        acc_pending = 1'b1;
      end
      rwait++;
    end else begin
      rwait = 0;
      req_ready = 1'($urandom_range(0, 1));
    end
    stub_busy = acc_pending || (rcnt > 0);
  end

  // compare process
  always @(negedge clock) begin
    if (chk_en) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== expq[0].data || rsp_err !== expq[0].err) begin
          n_bad++;
          $display("FAIL rsp cyc=%0d: got valid=%b data=%h err=%0d, want valid=1 data=%h err=%0d",
                   cyc, rsp_valid, rsp_data, rsp_err, expq[0].data, expq[0].err);
        end
        last_lat = cyc - cur_h + 1;
        last_data = rsp_data;
        last_err = rsp_err;
        void'(expq.pop_front());
      end else if (rsp_valid !== 1'b0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_rsp cyc=%0d: got valid=%b, want 0", cyc, rsp_valid);
      end
      if (req_valid !== 1'b0) begin
        n_cmp++;
        if (!exp_bus || bus_addr !== cur_addr || bus_data !== cur_wdata ||
            bus_fcn !== cur_fcn || bus_typ !== cur_typ) begin
          n_bad++;
          $display("FAIL bus cyc=%0d: got valid=%b addr=%h data=%h fcn=%b typ=%0d, want issue=%0b addr=%h data=%h fcn=%b typ=%0d",
                   cyc, req_valid, bus_addr, bus_data, bus_fcn, bus_typ,
                   exp_bus, cur_addr, cur_wdata, cur_fcn, cur_typ);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] typ, input logic sgn, input int a);
    logic [31:0] v;
    logic [15:0] h16;
    v = 32'd0;
    if (typ == 3'd1) begin
      v = {24'd0, ref_mem[a]};
      if (sgn && ref_mem[a][7]) v = v | 32'hFFFF_FF00;
    end else if (typ == 3'd2) begin
      h16 = {ref_mem[a + 1], ref_mem[a]};
      v = (sgn && h16[15]) ? {16'hFFFF, h16} : {16'h0000, h16};
    end else begin
      v = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    end
    return v;
  endfunction

  task automatic issue(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic sgn, input int dr,
                       input int dw, input bit track);
    int k, h, a, t, nb;
    exp_t e;
    k = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_wait: got %b, want 1", cmd_ready);
    end
    stub_dr = dr;
    stub_dw = dw;
    h = cyc + 1;
    e.data = 32'd0;
    if (typ == 3'd0 || typ > 3'd3 || (typ == 3'd2 && addr % 2 != 0) ||
        (typ == 3'd3 && addr % 4 != 0))
      e.err = 2'd1;
    else if (addr >= 32'(1 << MAB))
      e.err = 2'd2;
    else
      e.err = 2'd0;
    if (e.err != 2'd0) begin
      e.cyc = h;
    end else begin
      a = h + 1 + dr;
      t = h + TMO;
      nb = (typ == 3'd1) ? 1 : (typ == 3'd2) ? 2 : 4;
      if (a < t && fcn)
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      if (a >= t) begin
        e.cyc = t; e.err = 2'd3;
      end else if (dw != 0 && a + dw <= t) begin
        e.cyc = a + dw;
        e.data = fcn ? 32'd0 : model_load(typ, sgn, int'(addr));
      end else begin
        e.cyc = t; e.err = 2'd3;
      end
    end
    cur_h = h;
    exp_bus = (e.err == 2'd0) || (e.err == 2'd3);
    cur_addr = addr; cur_wdata = wdata; cur_fcn = fcn; cur_typ = typ;
    if (track) expq.push_back(e);
    cmd_fcn = fcn; cmd_typ = typ; cmd_addr = addr; cmd_wdata = wdata;
    cmd_signed = sgn; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_typ = 3'($urandom);
    if (track) begin
      k = 0;
      while ((expq.size() != 0 || stub_busy) && k < 100) begin
        @(negedge clock);
        k++;
      end
      if (k >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_wait: response queue still holds %0d entries, want 0", expq.size());
        expq.delete();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rt;
    logic [31:0] ra;
    logic        rf;
    int nb, sel, rdr, rdw;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'($urandom);
      smem[i] = ref_mem[i];
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_bus_data", bus_data, 32'd0);
    check("reset_bus_fcn_typ", {28'd0, bus_fcn, bus_typ}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // store then load of the same word
    issue(1'b1, 3'd3, 32'h8, 32'hDEADBEEF, 1'b0, 0, 1, 1'b1);
    check("store_lat", 32'(last_lat), 32'd3);
    issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b0, 0, 1, 1'b1);
    check("load_word_lat", 32'(last_lat), 32'd3);
    check("load_word_data", last_data, 32'hDEADBEEF);
    check("load_word_err", 32'(last_err), 32'd0);

    // sign/zero extension
    issue(1'b1, 3'd3, 32'h8, 32'h00F08000, 1'b0, 0, 1, 1'b1);
    issue(1'b0, 3'd1, 32'hA, 32'h0, 1'b1, 0, 1, 1'b1);
    check("lb_signed", last_data, 32'hFFFFFFF0);
    issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1, 2, 1'b1);
    check("lh_signed", last_data, 32'hFFFF8000);
    issue(1'b0, 3'd1, 32'hA, 32'h0, 1'b0, 0, 3, 1'b1);
    check("lb_unsigned", last_data, 32'h000000F0);

    // misaligned, out of range, illegal typ
    issue(1'b0, 3'd3, 32'h6, 32'h0, 1'b0, 0, 1, 1'b1);
    check("lw_misaligned_err", 32'(last_err), 32'd1);
    check("lw_misaligned_lat", 32'(last_lat), 32'd1);
    issue(1'b0, 3'd2, 32'h5, 32'h0, 1'b0, 0, 1, 1'b1);
    check("lh_misaligned_err", 32'(last_err), 32'd1);
    issue(1'b0, 3'd3, 32'h40, 32'h0, 1'b0, 0, 1, 1'b1);
    check("lw_range_err", 32'(last_err), 32'd2);
    check("lw_range_lat", 32'(last_lat), 32'd1);
    issue(1'b0, 3'd0, 32'h40, 32'h0, 1'b0, 0, 1, 1'b1);
    check("typ0_err", 32'(last_err), 32'd1);

    // timeouts
    issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b0, 0, 0, 1'b1);
    check("timeout_err", 32'(last_err), 32'd3);
    check("timeout_data", last_data, 32'd0);
    check("timeout_lat", 32'(last_lat), 32'(TMO + 1));
    issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b0, 0, 14, 1'b1);
    check("resp_on_timeout_err", 32'(last_err), 32'd0);
    check("resp_on_timeout_data", last_data, 32'h00F08000);
    issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b0, 0, 15, 1'b1);
    check("resp_after_timeout_err", 32'(last_err), 32'd3);
    issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b0, 20, 1, 1'b1);
    check("req_timeout_err", 32'(last_err), 32'd3);

    // reset while waiting, late response must be ignored
    issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, 0, 5, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("wait_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wait_reset_req_valid", 32'(req_valid), 32'd0);
    repeat (10) @(negedge clock);
    check("late_resp_cmd_ready", 32'(cmd_ready), 32'd1);
    check("late_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_resp_req_valid", 32'(req_valid), 32'd0);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      rf = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      rt = (sel == 0) ? ((($urandom_range(0, 1)) == 0) ? 3'd0 : 3'($urandom_range(4, 7)))
                      : 3'($urandom_range(1, 3));
      nb = (rt == 3'd1) ? 1 : (rt == 3'd2) ? 2 : 4;
      sel = $urandom_range(0, 7);
      if (sel == 0) ra = $urandom;
      else if (sel == 1) ra = 32'($urandom_range(64, 127));
      else begin
        ra = 32'($urandom_range(0, 63));
        ra = ra - (ra % 32'(nb));
        if (sel == 2 && nb > 1) ra = ra + 32'd1;
      end
      rdr = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel == 0) rdw = 0;
      else if (sel == 1) rdw = 14 - rdr;
      else if (sel == 2) rdw = 15 - rdr;
      else rdw = $urandom_range(1, 4);
      if (rdw < 1 && sel != 0) rdw = 1;
      issue(rf, rt, ra, $urandom, 1'($urandom_range(0, 1)), rdr, rdw, 1'b1);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
